// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared geometry, character codes and sequencer states for the VGA text controller
package vga_text_pkg;
   localparam int COLS = 70;
   localparam int ROWS = 30;
   localparam int COL_W = 7;
   localparam int ROW_W = 5;
   localparam logic [7:0] CLR_CHAR = 8'h20;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   typedef enum logic [1:0] {INIT_CLR, IDLE, SCROLL_CLR} state_t;
endpackage

// File: rtl/row_mod_add.sv
// row_mod_add: maps a logical text row onto a physical RAM row, (base + off) mod ROWS
//  i_base  top_row of the circular screen buffer
//  i_off   logical row
//  o_row   physical row
module row_mod_add
   import vga_text_pkg::*;
(
   input  logic [ROW_W-1:0] i_base,
   input  logic [ROW_W-1:0] i_off,
   output logic [ROW_W-1:0] o_row
);
   logic [ROW_W:0] w_sum;
   assign w_sum = {1'b0, i_base} + {1'b0, i_off};
   assign o_row = (w_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(w_sum - (ROW_W+1)'(ROWS)) : w_sum[ROW_W-1:0];
endmodule

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: text-mode sequencer owning cursor, scroll offset and character RAM write port
//  pclk/reset             pixel clock, synchronous active-high reset
//  in_valid/in_ready/in_char   ASCII input stream
//  scan_x/scan_y -> rd_addr, cursor_hit   scanout lookup, one cycle latency
//  wr_en/wr_addr/wr_data  character RAM write port
//  cur_x/cur_y            cursor position (logical row)
module vga_text_ctrl
   import vga_text_pkg::*;
#(
   parameter int BLINK_CYCLES = 12_500_000
)(
   input  logic             pclk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   input  logic [COL_W-1:0] scan_x,
   input  logic [ROW_W-1:0] scan_y,
   output logic [11:0]      rd_addr,
   output logic             cursor_hit,
   output logic             wr_en,
   output logic [11:0]      wr_addr,
   output logic [7:0]       wr_data,
   output logic [COL_W-1:0] cur_x,
   output logic [ROW_W-1:0] cur_y
);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   state_t r_state, w_state;
   logic [COL_W-1:0] r_cx, w_cx, r_ccol, w_ccol;
   logic [ROW_W-1:0] r_cy, w_cy, r_top, w_top, r_crow, w_crow, w_lrow, w_wrow, w_rrow;
   logic r_wr_en, w_wr_en, w_nl, w_accept, w_printable, w_bs_up, w_last_col, w_blink_wrap;
   logic [11:0] r_wr_addr, w_wr_addr, r_rd_addr;
   logic [7:0] r_wr_data, w_wr_data;
   logic [BW-1:0] r_blink_cnt;
   logic r_blink_on, r_hit;
   assign in_ready = r_state == IDLE;
   assign w_accept = in_valid && in_ready;
   assign w_printable = in_char >= 8'h20 && in_char <= 8'h7E;
   // backspace from column 0 targets the end of the previous logical row
   assign w_bs_up = in_char == ASCII_BS && r_cx == '0;
   assign w_lrow = w_bs_up ? r_cy - 5'd1 : r_cy;
   assign w_last_col = r_ccol == LAST_COL;
   assign w_blink_wrap = r_blink_cnt == BW'(BLINK_CYCLES - 1);
   row_mod_add u_wr_row (.i_base(r_top), .i_off(w_lrow), .o_row(w_wrow));
   row_mod_add u_rd_row (.i_base(r_top), .i_off(scan_y), .o_row(w_rrow));
   always_comb begin
      w_state = r_state;
      w_cx = r_cx;
      w_cy = r_cy;
      w_top = r_top;
      w_crow = r_crow;
      w_ccol = r_ccol;
      w_wr_en = 1'b0;
      w_wr_addr = r_wr_addr;
      w_wr_data = r_wr_data;
      w_nl = 1'b0;
      case (r_state)
         INIT_CLR, SCROLL_CLR: begin
            w_wr_en = 1'b1;
            w_wr_addr = {r_crow, r_ccol};
            w_wr_data = CLR_CHAR;
            w_ccol = w_last_col ? '0 : r_ccol + 7'd1;
            if (r_state == INIT_CLR) w_crow = w_last_col ? r_crow + 5'd1 : r_crow;
            if (w_last_col && (r_state == SCROLL_CLR || r_crow == LAST_ROW)) w_state = IDLE;
         end
         default: if (w_accept) begin
            if (w_printable) begin
               w_wr_en = 1'b1;
               w_wr_addr = {w_wrow, r_cx};
               w_wr_data = in_char;
               w_cx = r_cx + 7'd1;
               w_nl = r_cx == LAST_COL;
            end else if (in_char == ASCII_LF || in_char == ASCII_CR) begin
               w_nl = 1'b1;
            end else if (in_char == ASCII_BS && (r_cx != '0 || r_cy != '0)) begin
               w_wr_en = 1'b1;
               w_cx = w_bs_up ? LAST_COL : r_cx - 7'd1;
               w_cy = w_lrow;
               w_wr_addr = {w_wrow, w_cx};
               w_wr_data = CLR_CHAR;
            end
            if (w_nl) begin
               w_cx = '0;
               w_cy = (r_cy == LAST_ROW) ? r_cy : r_cy + 5'd1;
               // scrolling: the old top row becomes the new bottom row and is blanked
               if (r_cy == LAST_ROW) begin
                  w_top = (r_top == LAST_ROW) ? '0 : r_top + 5'd1;
                  w_crow = r_top;
                  w_ccol = '0;
                  w_state = SCROLL_CLR;
               end
            end
         end
      endcase
   end
   always_ff @(posedge pclk) begin
      if (reset) begin
         r_state <= INIT_CLR;
         r_cx <= '0;
         r_cy <= '0;
         r_top <= '0;
         r_crow <= '0;
         r_ccol <= '0;
         r_wr_en <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= CLR_CHAR;
      end else begin
         r_state <= w_state;
         r_cx <= w_cx;
         r_cy <= w_cy;
         r_top <= w_top;
         r_crow <= w_crow;
         r_ccol <= w_ccol;
         r_wr_en <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
      end
   end
   always_ff @(posedge pclk) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_blink_on <= 1'b1;
         r_rd_addr <= '0;
         r_hit <= 1'b0;
      end else begin
         r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
         r_blink_on <= w_blink_wrap ? ~r_blink_on : r_blink_on;
         r_rd_addr <= {w_rrow, scan_x};
         r_hit <= r_blink_on && scan_x == r_cx && scan_y == r_cy;
      end
   end
   assign rd_addr = r_rd_addr;
   assign cursor_hit = r_hit;
   assign wr_en = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign cur_x = r_cx;
   assign cur_y = r_cy;
endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: vector table, directed corner sequences and randomized traffic against a screen-level model
module tb_vga_text_ctrl;
   import vga_text_pkg::*;
   localparam int B = 20;
   logic pclk = 1'b0, reset = 1'b1, in_valid = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic [6:0] scan_x = '0;
   logic [4:0] scan_y = '0;
   logic in_ready, cursor_hit, wr_en;
   logic [11:0] rd_addr, wr_addr;
   logic [7:0] wr_data;
   logic [6:0] cur_x;
   logic [4:0] cur_y;
   int checks = 0, failures = 0, wr_cnt = 0, ecnt = 0, mx = 0, my = 0, mt = 0;
   logic [19:0] expq[$];
   logic [19:0] mon_e;
   typedef struct {logic [7:0] ch; bit wr; logic [11:0] addr; logic [7:0] data; int cx; int cy;} vec_t;
   vec_t tbl[14];

   vga_text_ctrl #(.BLINK_CYCLES(B)) dut (
      .pclk(pclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
      .scan_x(scan_x), .scan_y(scan_y), .rd_addr(rd_addr), .cursor_hit(cursor_hit),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_x(cur_x), .cur_y(cur_y)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) ecnt <= reset ? 0 : ecnt + 1;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   always @(negedge pclk) if (wr_en) begin
      wr_cnt++;
      if (expq.size() == 0) chk(1'b0, "unexpected_write", int'({wr_addr, wr_data}), 0);
      else begin
         mon_e = expq.pop_front();
         chk({wr_addr, wr_data} == mon_e, "write_addr_data", int'({wr_addr, wr_data}), int'(mon_e));
      end
   end

   function automatic int phys(input int r);
      return (mt + r) % ROWS;
   endfunction

   task automatic push(input int row, input int col, input int d);
      expq.push_back({row[4:0], col[6:0], d[7:0]});
   endtask

   task automatic model_nl();
      mx = 0;
      if (my < ROWS - 1) my++;
      else begin
         for (int c = 0; c < COLS; c++) push(mt, c, 32);
         mt = (mt + 1) % ROWS;
      end
   endtask

   task automatic model_accept(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         push(phys(my), mx, int'(c));
         if (mx == COLS - 1) model_nl();
         else mx++;
      end else if (c == 8'h0A || c == 8'h0D) model_nl();
      else if (c == 8'h08) begin
         if (mx > 0) begin
            mx--;
            push(phys(my), mx, 32);
         end else if (my > 0) begin
            my--;
            mx = COLS - 1;
            push(phys(my), mx, 32);
         end
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!in_ready && n < 3000) begin
         @(negedge pclk);
         n++;
      end
   endtask

   task automatic send(input logic [7:0] c);
      int n;
      in_char = c;
      in_valid = 1'b1;
      wait_ready(n);
      if (in_ready) model_accept(c);
      else chk(1'b0, "ready_timeout", n, 3000);
      @(negedge pclk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge pclk);
      expq.delete();
      mx = 0;
      my = 0;
      mt = 0;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) push(r, c, 32);
      @(negedge pclk);
      reset = 1'b0;
      chk(wr_en == 1'b0, "reset_wr_en", int'(wr_en), 0);
      chk(wr_addr == 12'h000, "reset_wr_addr", int'(wr_addr), 0);
      chk(wr_data == 8'h20, "reset_wr_data", int'(wr_data), 32'h20);
      chk(rd_addr == 12'h000, "reset_rd_addr", int'(rd_addr), 0);
      chk(cursor_hit == 1'b0, "reset_cursor_hit", int'(cursor_hit), 0);
      chk(cur_x == 7'd0 && cur_y == 5'd0, "reset_cursor", int'({cur_y, cur_x}), 0);
      chk(in_ready == 1'b0, "reset_in_ready", int'(in_ready), 0);
   endtask

   task automatic wait_init();
      int n;
      int w0 = wr_cnt;
      wait_ready(n);
      @(negedge pclk);
      chk(n == ROWS * COLS, "init_busy_cycles", n, ROWS * COLS);
      chk(wr_cnt - w0 == ROWS * COLS, "init_write_count", wr_cnt - w0, ROWS * COLS);
      chk(expq.size() == 0, "init_writes_pending", expq.size(), 0);
      chk(cur_x == 7'd0 && cur_y == 5'd0, "init_cursor", int'({cur_y, cur_x}), 0);
   endtask

   task automatic scan_chk(input int sx, input int sy);
      bit on;
      scan_x = 7'(sx);
      scan_y = 5'(sy);
      @(negedge pclk);
      on = ((ecnt - 1) / B) % 2 == 0;
      chk(rd_addr == {5'(phys(sy)), 7'(sx)}, "scan_rd_addr", int'(rd_addr), phys(sy) * 128 + sx);
      chk(cursor_hit == (on && sx == mx && sy == my), "scan_cursor_hit", int'(cursor_hit), int'(on && sx == mx && sy == my));
   endtask

   function automatic logic [7:0] rand_char();
      int r = int'($urandom_range(99));
      logic [7:0] c = 8'($urandom_range(255));
      if (r < 60) return 8'($urandom_range(8'h7E, 8'h20));
      if (r < 72) return 8'h0A;
      if (r < 78) return 8'h0D;
      if (r < 92) return 8'h08;
      return (c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A || c == 8'h0D ? 8'h7F : c;
   endfunction

   initial begin
      int n, w0, sx, sy;
      tbl[0] = '{8'h41, 1'b1, 12'h000, 8'h41, 1, 0};
      tbl[1] = '{8'h08, 1'b1, 12'h000, 8'h20, 0, 0};
      tbl[2] = '{8'h08, 1'b0, 12'h000, 8'h00, 0, 0};
      tbl[3] = '{8'h0A, 1'b0, 12'h000, 8'h00, 0, 1};
      tbl[4] = '{8'h08, 1'b1, 12'h045, 8'h20, 69, 0};
      tbl[5] = '{8'h7E, 1'b1, 12'h045, 8'h7E, 0, 1};
      tbl[6] = '{8'h7A, 1'b1, 12'h080, 8'h7A, 1, 1};
      tbl[7] = '{8'h0D, 1'b0, 12'h000, 8'h00, 0, 2};
      tbl[8] = '{8'h1F, 1'b0, 12'h000, 8'h00, 0, 2};
      tbl[9] = '{8'h7F, 1'b0, 12'h000, 8'h00, 0, 2};
      tbl[10] = '{8'h80, 1'b0, 12'h000, 8'h00, 0, 2};
      tbl[11] = '{8'h20, 1'b1, 12'h100, 8'h20, 1, 2};
      tbl[12] = '{8'h08, 1'b1, 12'h100, 8'h20, 0, 2};
      tbl[13] = '{8'h08, 1'b1, 12'h0C5, 8'h20, 69, 1};
      @(negedge pclk);
      do_reset();
      wait_init();
      for (int i = 0; i < 14; i++) begin
         send(tbl[i].ch);
         chk(wr_en == tbl[i].wr, $sformatf("vec%0d_wr_en", i), int'(wr_en), int'(tbl[i].wr));
         if (tbl[i].wr) begin
            chk(wr_addr == tbl[i].addr, $sformatf("vec%0d_wr_addr", i), int'(wr_addr), int'(tbl[i].addr));
            chk(wr_data == tbl[i].data, $sformatf("vec%0d_wr_data", i), int'(wr_data), int'(tbl[i].data));
         end
         chk(int'(cur_x) == tbl[i].cx && int'(cur_y) == tbl[i].cy, $sformatf("vec%0d_cursor", i),
             int'({cur_y, cur_x}), tbl[i].cy * 128 + tbl[i].cx);
      end
      do_reset();
      wait_init();
      repeat (70) send(8'h42);
      chk(wr_en && wr_addr == 12'h045 && wr_data == 8'h42, "row_fill_last_write", int'({wr_addr, wr_data}), 32'h04542);
      chk(cur_x == 7'd0 && cur_y == 5'd1, "row_fill_cursor", int'({cur_y, cur_x}), 128);
      do_reset();
      wait_init();
      repeat (29) send(8'h0A);
      chk(cur_x == 7'd0 && cur_y == 5'd29, "lf29_cursor", int'({cur_y, cur_x}), 29 * 128);
      w0 = wr_cnt;
      send(8'h0A);
      wait_ready(n);
      @(negedge pclk);
      chk(n == COLS, "scroll_busy_cycles", n, COLS);
      chk(wr_cnt - w0 == COLS, "scroll_write_count", wr_cnt - w0, COLS);
      chk(expq.size() == 0, "scroll_writes_pending", expq.size(), 0);
      chk(cur_x == 7'd0 && cur_y == 5'd29, "scroll_cursor", int'({cur_y, cur_x}), 29 * 128);
      scan_x = 7'd5;
      scan_y = 5'd0;
      @(negedge pclk);
      chk(rd_addr == 12'h085, "scroll_rd_addr", int'(rd_addr), 32'h085);
      send(8'h0A);
      repeat (9) @(negedge pclk);
      chk(in_ready == 1'b0, "mid_scroll_busy", int'(in_ready), 0);
      do_reset();
      wait_init();
      scan_x = 7'd5;
      scan_y = 5'd0;
      @(negedge pclk);
      chk(rd_addr == 12'h005, "reset_top_row", int'(rd_addr), 32'h005);
      for (int i = 0; i < 1500; i++) begin
         send(rand_char());
         repeat ($urandom_range(2)) @(negedge pclk);
         if (i % 150 == 149) for (int k = 0; k < 40; k++) begin
            sx = $urandom_range(1) == 1 ? mx : int'($urandom_range(COLS - 1));
            sy = $urandom_range(1) == 1 ? my : int'($urandom_range(ROWS - 1));
            scan_chk(sx, sy);
         end
      end
      wait_ready(n);
      @(negedge pclk);
      chk(n < 3000, "final_drain", n, 0);
      chk(expq.size() == 0, "final_writes_pending", expq.size(), 0);
      chk(int'(cur_x) == mx && int'(cur_y) == my, "final_cursor", int'({cur_y, cur_x}), my * 128 + mx);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
